// File: rtl/clk_div_gen.sv
// Programmable clock divider: produces a registered divided square wave, a
// period-start tick and a glitch-free divisor change at period boundaries.
// Optional feature macro: CLK_DIV_PERIOD_CNT_EN adds a 16-bit period counter.
module clk_div_gen #(
    parameter int unsigned DIV_WIDTH = 8,
    parameter int unsigned DIV_RESET = 4
) (
    input  logic                 clk_hf,
    input  logic                 rst,
    input  logic                 en,
    input  logic [DIV_WIDTH-1:0] div_in,
    input  logic                 div_load,
    output logic                 div_ack,
    output logic                 div_err,
    output logic                 clk_out,
    output logic                 tick,
    output logic [DIV_WIDTH-1:0] div_cur
`ifdef CLK_DIV_PERIOD_CNT_EN
    ,
    output logic [15:0]          period_cnt
`endif
);

    localparam int unsigned HALF_W = DIV_WIDTH + 1;
    localparam logic [DIV_WIDTH-1:0] DIV_RST = DIV_WIDTH'(DIV_RESET);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic [DIV_WIDTH-1:0] div_cur_q, div_cur_d;
    logic [DIV_WIDTH-1:0] pend_div_q, pend_div_d;
    logic                 pend_q, pend_d;
    logic                 clk_out_q, clk_out_d;
    logic                 tick_q, tick_d;
    logic                 div_ack_q, div_ack_d;
    logic                 div_err_q, div_err_d;

    logic                 load_ok;
    logic                 wrap;
    logic                 running_d;

    // Length of the high phase: ceil(n/2), computed one bit wider to avoid overflow.
    function automatic logic [HALF_W-1:0] high_len(input logic [DIV_WIDTH-1:0] n);
        logic [HALF_W-1:0] sum;
        sum = HALF_W'(n) + HALF_W'(1);
        return sum >> 1;
    endfunction

    // Next-state, counter, divisor handoff and registered-output computation.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        div_cur_d  = div_cur_q;
        pend_d     = pend_q;
        pend_div_d = pend_div_q;
        div_ack_d  = 1'b0;
        div_err_d  = div_load && (div_in == '0);
        load_ok    = div_load && (div_in != '0);
        wrap       = (cnt_q == (div_cur_q - DIV_WIDTH'(1)));

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                // Counter is stopped, so a new divisor can take effect immediately.
                if (load_ok) begin
                    div_cur_d = div_in;
                    div_ack_d = 1'b1;
                    pend_d    = 1'b0;
                end else if (pend_q) begin
                    div_cur_d = pend_div_q;
                    div_ack_d = 1'b1;
                    pend_d    = 1'b0;
                end
                if (en) begin
                    state_d = RUN;
                end
            end
            RUN, STOP: begin
                if (wrap) begin
                    cnt_d = '0;
                    if (pend_q) begin
                        div_cur_d = pend_div_q;
                        div_ack_d = 1'b1;
                        pend_d    = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + DIV_WIDTH'(1);
                end
                // A load on the wrap cycle is deferred to the following wrap.
                if (load_ok) begin
                    pend_d     = 1'b1;
                    pend_div_d = div_in;
                end
                // Stopping only takes effect at a period boundary.
                if (en) begin
                    state_d = RUN;
                end else if (wrap) begin
                    state_d = IDLE;
                end else begin
                    state_d = STOP;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        running_d = (state_d != IDLE);
        tick_d    = running_d && (cnt_d == '0);
        clk_out_d = running_d && (HALF_W'(cnt_d) < high_len(div_cur_d));
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_hf) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            div_cur_q  <= DIV_RST;
            pend_q     <= 1'b0;
            pend_div_q <= '0;
            clk_out_q  <= 1'b0;
            tick_q     <= 1'b0;
            div_ack_q  <= 1'b0;
            div_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_cur_q  <= div_cur_d;
            pend_q     <= pend_d;
            pend_div_q <= pend_div_d;
            clk_out_q  <= clk_out_d;
            tick_q     <= tick_d;
            div_ack_q  <= div_ack_d;
            div_err_q  <= div_err_d;
        end
    end

    assign clk_out = clk_out_q;
    assign tick    = tick_q;
    assign div_ack = div_ack_q;
    assign div_err = div_err_q;
    assign div_cur = div_cur_q;

`ifdef CLK_DIV_PERIOD_CNT_EN
    localparam int unsigned PCNT_W = 16;

    logic [PCNT_W-1:0] period_cnt_q, period_cnt_d;

    // Count periods, advancing together with each tick; wraps naturally.
    always_comb begin
        period_cnt_d = period_cnt_q;
        if (tick_d) begin
            period_cnt_d = period_cnt_q + PCNT_W'(1);
        end
    end

    // Period counter register.
    always_ff @(posedge clk_hf) begin
        if (rst) begin
            period_cnt_q <= '0;
        end else begin
            period_cnt_q <= period_cnt_d;
        end
    end

    assign period_cnt = period_cnt_q;
`endif

endmodule

// File: tb/tb_clk_div_gen.sv
// Self-checking bench for clk_div_gen: vector table plus hand-written corner
// sequences, expected outputs queued at drive time and popped after the edge.
module tb_clk_div_gen;

    localparam int unsigned DW = 8;

    typedef struct {
        logic          rst;
        logic          en;
        logic          ld;
        logic [DW-1:0] din;
        logic          co;
        logic          tk;
        logic          ack;
        logic          err;
        logic [DW-1:0] cur;
    } vec_t;

    typedef struct {
        int            idx;
        logic          co;
        logic          tk;
        logic          ack;
        logic          err;
        logic [DW-1:0] cur;
    } exp_t;

    logic          clk_hf;
    logic          rst;
    logic          en;
    logic [DW-1:0] div_in;
    logic          div_load;
    logic          div_ack;
    logic          div_err;
    logic          clk_out;
    logic          tick;
    logic [DW-1:0] div_cur;

    int checks;
    int errors;
    int step_no;

    vec_t vecs[$];
    exp_t exp_q[$];

    clk_div_gen #(
        .DIV_WIDTH(DW),
        .DIV_RESET(4)
    ) dut (
        .clk_hf  (clk_hf),
        .rst     (rst),
        .en      (en),
        .div_in  (div_in),
        .div_load(div_load),
        .div_ack (div_ack),
        .div_err (div_err),
        .clk_out (clk_out),
        .tick    (tick),
        .div_cur (div_cur)
    );

    initial clk_hf = 1'b0;
    always #5 clk_hf = ~clk_hf;

    function automatic vec_t mk(input logic r, input logic e, input logic l,
                                input int d, input logic co, input logic tk,
                                input logic ack, input logic err, input int cur);
        vec_t v;
        v.rst = r;   v.en = e;   v.ld = l;   v.din = DW'(d);
        v.co = co;   v.tk = tk;  v.ack = ack; v.err = err; v.cur = DW'(cur);
        return v;
    endfunction

    task automatic cmp(input string name, input int idx, input logic [DW-1:0] act,
                       input logic [DW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL step %0d %s: got %0h expected %0h", idx, name, act, req);
        end
    endtask

    // Drive one cycle of stimulus, queue its expectation, then check after the edge.
    task automatic cycle(input vec_t v);
        exp_t e;
        exp_t got;
        rst      = v.rst;
        en       = v.en;
        div_load = v.ld;
        div_in   = v.din;
        e.idx = step_no; e.co = v.co; e.tk = v.tk; e.ack = v.ack; e.err = v.err; e.cur = v.cur;
        exp_q.push_back(e);
        step_no++;
        @(posedge clk_hf);
        #1;
        got = exp_q.pop_front();
        cmp("clk_out", got.idx, DW'(clk_out), DW'(got.co));
        cmp("tick",    got.idx, DW'(tick),    DW'(got.tk));
        cmp("div_ack", got.idx, DW'(div_ack), DW'(got.ack));
        cmp("div_err", got.idx, DW'(div_err), DW'(got.err));
        cmp("div_cur", got.idx, div_cur,      got.cur);
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        step_no  = 0;
        rst      = 1'b0;
        en       = 1'b0;
        div_load = 1'b0;
        div_in   = '0;

        // Reset, then N=4 free-running: 1100 pattern.
        vecs.push_back(mk(1,0,0,0, 0,0,0,0,4));
        vecs.push_back(mk(1,0,0,0, 0,0,0,0,4));
        vecs.push_back(mk(0,0,0,0, 0,0,0,0,4));
        vecs.push_back(mk(0,1,0,0, 1,1,0,0,4));
        vecs.push_back(mk(0,1,0,0, 1,0,0,0,4));
        vecs.push_back(mk(0,1,0,0, 0,0,0,0,4));
        vecs.push_back(mk(0,1,0,0, 0,0,0,0,4));
        vecs.push_back(mk(0,1,0,0, 1,1,0,0,4));
        vecs.push_back(mk(0,1,0,0, 1,0,0,0,4));
        vecs.push_back(mk(0,1,0,0, 0,0,0,0,4));
        vecs.push_back(mk(0,1,0,0, 0,0,0,0,4));
        // Load 5 at cnt=1: period of 4 completes, then 11100 with ack.
        vecs.push_back(mk(0,1,0,0, 1,1,0,0,4));
        vecs.push_back(mk(0,1,0,0, 1,0,0,0,4));
        vecs.push_back(mk(0,1,1,5, 0,0,0,0,4));
        vecs.push_back(mk(0,1,0,0, 0,0,0,0,4));
        vecs.push_back(mk(0,1,0,0, 1,1,1,0,5));
        vecs.push_back(mk(0,1,0,0, 1,0,0,0,5));
        vecs.push_back(mk(0,1,0,0, 1,0,0,0,5));
        vecs.push_back(mk(0,1,0,0, 0,0,0,0,5));
        vecs.push_back(mk(0,1,0,0, 0,0,0,0,5));
        vecs.push_back(mk(0,1,0,0, 1,1,0,0,5));
        vecs.push_back(mk(0,1,0,0, 1,0,0,0,5));
        vecs.push_back(mk(0,1,0,0, 1,0,0,0,5));
        vecs.push_back(mk(0,1,0,0, 0,0,0,0,5));
        vecs.push_back(mk(0,1,0,0, 0,0,0,0,5));
        // Zero divisor: single err pulse, nothing else disturbed.
        vecs.push_back(mk(0,1,1,0, 1,1,0,1,5));
        vecs.push_back(mk(0,1,0,0, 1,0,0,0,5));
        vecs.push_back(mk(0,1,0,0, 1,0,0,0,5));
        vecs.push_back(mk(0,1,0,0, 0,0,0,0,5));
        vecs.push_back(mk(0,1,0,0, 0,0,0,0,5));
        // Load 6 on the wrap cycle: deferred one full period.
        vecs.push_back(mk(0,1,1,6, 1,1,0,0,5));
        vecs.push_back(mk(0,1,0,0, 1,0,0,0,5));
        vecs.push_back(mk(0,1,0,0, 1,0,0,0,5));
        vecs.push_back(mk(0,1,0,0, 0,0,0,0,5));
        vecs.push_back(mk(0,1,0,0, 0,0,0,0,5));
        vecs.push_back(mk(0,1,0,0, 1,1,1,0,6));
        vecs.push_back(mk(0,1,0,0, 1,0,0,0,6));
        // en dropped at cnt=1 with N=6: 111000 completes, then IDLE.
        vecs.push_back(mk(0,0,0,0, 1,0,0,0,6));
        vecs.push_back(mk(0,0,0,0, 0,0,0,0,6));
        vecs.push_back(mk(0,0,0,0, 0,0,0,0,6));
        vecs.push_back(mk(0,0,0,0, 0,0,0,0,6));
        vecs.push_back(mk(0,0,0,0, 0,0,0,0,6));
        vecs.push_back(mk(0,0,0,0, 0,0,0,0,6));
        // Restart, drop en at cnt=1, raise again at cnt=3: no gap.
        vecs.push_back(mk(0,1,0,0, 1,1,0,0,6));
        vecs.push_back(mk(0,1,0,0, 1,0,0,0,6));
        vecs.push_back(mk(0,0,0,0, 1,0,0,0,6));
        vecs.push_back(mk(0,0,0,0, 0,0,0,0,6));
        vecs.push_back(mk(0,1,0,0, 0,0,0,0,6));
        vecs.push_back(mk(0,1,0,0, 0,0,0,0,6));
        vecs.push_back(mk(0,1,0,0, 1,1,0,0,6));
        vecs.push_back(mk(0,1,0,0, 1,0,0,0,6));
        // Loads 3 then 7 back to back: one ack, N=7 gives 1111000.
        vecs.push_back(mk(0,1,1,3, 1,0,0,0,6));
        vecs.push_back(mk(0,1,1,7, 0,0,0,0,6));
        vecs.push_back(mk(0,1,0,0, 0,0,0,0,6));
        vecs.push_back(mk(0,1,0,0, 0,0,0,0,6));
        vecs.push_back(mk(0,1,0,0, 1,1,1,0,7));
        vecs.push_back(mk(0,1,0,0, 1,0,0,0,7));
        vecs.push_back(mk(0,1,0,0, 1,0,0,0,7));
        vecs.push_back(mk(0,1,0,0, 1,0,0,0,7));
        vecs.push_back(mk(0,1,0,0, 0,0,0,0,7));
        vecs.push_back(mk(0,1,0,0, 0,0,0,0,7));
        vecs.push_back(mk(0,1,0,0, 0,0,0,0,7));
        vecs.push_back(mk(0,1,0,0, 1,1,0,0,7));
        vecs.push_back(mk(0,1,0,0, 1,0,0,0,7));

        for (int i = 0; i < vecs.size(); i++) begin
            cycle(vecs[i]);
        end

        // Reset at cnt=2 with a pending load: pending value is discarded.
        cycle(mk(0,1,1,2, 1,0,0,0,7));
        cycle(mk(1,1,1,9, 0,0,0,0,4));
        cycle(mk(0,0,0,0, 0,0,0,0,4));
        cycle(mk(0,0,0,0, 0,0,0,0,4));
        cycle(mk(0,1,0,0, 1,1,0,0,4));
        cycle(mk(0,1,0,0, 1,0,0,0,4));
        cycle(mk(0,1,0,0, 0,0,0,0,4));
        cycle(mk(0,1,0,0, 0,0,0,0,4));
        cycle(mk(0,1,0,0, 1,1,0,0,4));
        cycle(mk(0,0,0,0, 1,0,0,0,4));
        cycle(mk(0,0,0,0, 0,0,0,0,4));
        cycle(mk(0,0,0,0, 0,0,0,0,4));
        cycle(mk(0,0,0,0, 0,0,0,0,4));

        // IDLE load of N=1 and IDLE zero load; N=1 runs constantly high with tick.
        cycle(mk(0,0,1,1, 0,0,1,0,1));
        cycle(mk(0,0,0,0, 0,0,0,0,1));
        cycle(mk(0,0,1,0, 0,0,0,1,1));
        cycle(mk(0,1,0,0, 1,1,0,0,1));
        cycle(mk(0,1,0,0, 1,1,0,0,1));
        cycle(mk(0,1,0,0, 1,1,0,0,1));
        cycle(mk(1,1,0,0, 0,0,0,0,4));

        // IDLE load of odd N=3 together with en: 110 pattern from the first cycle.
        cycle(mk(0,1,1,3, 1,1,1,0,3));
        cycle(mk(0,1,0,0, 1,0,0,0,3));
        cycle(mk(0,1,0,0, 0,0,0,0,3));
        cycle(mk(0,1,0,0, 1,1,0,0,3));
        cycle(mk(0,1,0,0, 1,0,0,0,3));

        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard: %0d entries left, expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
